// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode pipeline register: pairs an opcode word with its trailing
// immediate word and presents one packet per instruction to decode.
//
// state  | meaning
// FIRST  | expecting an opcode word
// SECOND | opcode held, expecting its immediate word
module fetch_decode_buffer #(
  parameter int IMM_FLAG_BIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_instruction,
  input  logic [31:0] fetch_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        decode_valid,
  output logic [15:0] decode_instruction,
  output logic [15:0] decode_immediate,
  output logic [31:0] decode_pc,
  output logic [31:0] decode_next_pc,
  output logic        waiting_immediate,
  output logic [15:0] issued_count
);

  typedef enum logic {FIRST, SECOND} state_t;

  state_t      state;
  logic [15:0] held_instruction;
  logic [31:0] held_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= FIRST;
      held_instruction   <= '0;
      held_pc            <= '0;
      decode_valid       <= 1'b0;
      decode_instruction <= '0;
      decode_immediate   <= '0;
      decode_pc          <= '0;
      decode_next_pc     <= '0;
      issued_count       <= '0;
    end else if (flush) begin
      // flush wins over stall; presented fields other than valid are left as-is
      state        <= FIRST;
      decode_valid <= 1'b0;
    end else if (!stall) begin
      case (state)
        FIRST: begin
          if (!fetch_valid) begin
            decode_valid <= 1'b0;
          end else if (fetch_instruction[IMM_FLAG_BIT]) begin
            held_instruction <= fetch_instruction;
            held_pc          <= fetch_pc;
            state            <= SECOND;
            decode_valid     <= 1'b0;
          end else begin
            decode_instruction <= fetch_instruction;
            decode_immediate   <= '0;
            decode_pc          <= fetch_pc;
            decode_next_pc     <= fetch_pc + 32'd1;
            decode_valid       <= 1'b1;
            issued_count       <= issued_count + 16'd1;
          end
        end
        SECOND: begin
          // the immediate word's flag bit is data, not a marker
          if (!fetch_valid) begin
            decode_valid <= 1'b0;
          end else begin
            decode_instruction <= held_instruction;
            decode_immediate   <= fetch_instruction;
            decode_pc          <= held_pc;
            decode_next_pc     <= held_pc + 32'd2;
            decode_valid       <= 1'b1;
            issued_count       <= issued_count + 16'd1;
            state              <= FIRST;
          end
        end
        default: state <= FIRST;
      endcase
    end
  end

  assign waiting_immediate = (state == SECOND);

endmodule
